// File: rtl/keyed_c17_pkg.sv
// Shared constants and types for the key-locked c17 lane array.
package keyed_c17_pkg;
    localparam int KEY_W = 4;

    // Key bit positions: which mux each key bit steers.
    localparam int K_M0 = 0;
    localparam int K_M1 = 1;
    localparam int K_M2 = 2;
    localparam int K_M3 = 3;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        ACTIVE = 2'd3
    } key_state_e;
endpackage

// File: rtl/c17_slice.sv
// One combinational c17 lane with key-selected muxes; the loop path goes through fb.
module c17_slice
    import keyed_c17_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic             fb,
    input  logic             n1,
    input  logic             n2,
    input  logic             n3,
    input  logic             n6,
    input  logic             n7,
    output logic             n22,
    output logic             n23
);
    logic m0, m1, m2, m3;
    logic n10, n11, n16, n19;

    assign m1  = key[K_M1] ? n2 : n1;
    assign m0  = key[K_M0] ? fb : m1;
    assign n10 = ~(m0 & n3);
    assign n11 = ~(n3 & n6);
    assign n16 = ~(n2 & n11);
    assign n19 = ~(n11 & n7);
    assign m3  = key[K_M3] ? fb : n10;
    // Decoy mux: both legs are the same net, so k2 never changes the function.
    assign m2  = key[K_M2] ? m3 : m3;
    assign n22 = ~(m2 & n16);
    assign n23 = ~(n16 & n19);
endmodule

// File: rtl/keyed_c17_array.sv
// LANES keyed c17 slices behind a serial key loader, one registered output stage
// and per-lane N22 feedback registers.
module keyed_c17_array
    import keyed_c17_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_valid,
    input  logic             key_sin,
    output logic             key_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_n1,
    input  logic [LANES-1:0] in_n2,
    input  logic [LANES-1:0] in_n3,
    input  logic [LANES-1:0] in_n6,
    input  logic [LANES-1:0] in_n7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_n22,
    output logic [LANES-1:0] out_n23
);
    key_state_e       state;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] key;
    logic [1:0]       cnt;
    logic [LANES-1:0] fb;
    logic [LANES-1:0] n22, n23;
    logic             accept;

    assign key_busy = (state == SHIFT) || (state == COMMIT);
    assign in_ready = (state == ACTIVE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        c17_slice u_slice (
            .key (key),
            .fb  (fb[i]),
            .n1  (in_n1[i]),
            .n2  (in_n2[i]),
            .n3  (in_n3[i]),
            .n6  (in_n6[i]),
            .n7  (in_n7[i]),
            .n22 (n22[i]),
            .n23 (n23[i])
        );
    end

    // Key loader: bits arrive k0 first and shift in from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOCKED;
            shadow <= '0;
            key    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                LOCKED: if (key_start) begin
                    state <= SHIFT;
                    cnt   <= '0;
                end
                SHIFT: if (key_start) begin
                    cnt <= '0;
                end else if (key_valid) begin
                    shadow <= {key_sin, shadow[KEY_W-1:1]};
                    cnt    <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= COMMIT;
                end
                COMMIT: begin
                    key   <= shadow;
                    state <= ACTIVE;
                end
                ACTIVE: if (key_start) begin
                    state <= SHIFT;
                    cnt   <= '0;
                end
                default: state <= LOCKED;
            endcase
        end
    end

    // Output stage drains regardless of loader state; only acceptance is gated.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb        <= '0;
            out_valid <= 1'b0;
            out_n22   <= '0;
            out_n23   <= '0;
        end else begin
            if (state == COMMIT) fb <= '0;
            else if (accept)     fb <= n22;

            if (accept) begin
                out_valid <= 1'b1;
                out_n22   <= n22;
                out_n23   <= n23;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/keyed_c17_array.md
# keyed_c17_array

Parametrised, sequential successor to the cyclic-mux-locked c17 netlist. LANES independent c17 slices share one 4-bit key. The key is loaded serially through a small FSM. Every key-selected feedback path is broken by a per-lane N22 register, so the block contains no combinational loops. Vectors flow through a single registered stage with valid/ready handshakes. The block sits between the obfuscation test harness and the key-provisioning port.

## Interface
- LANES, default 4: number of parallel c17 slices (1..32).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_start  in  1  pulse; begins a new key load (abandons any partial load).
- key_valid  in  1  key_sin carries a key bit this cycle.
- key_sin  in  1  serial key bit; k0 first, then k1, k2, k3.
- key_busy  out  1  high in SHIFT or COMMIT.
- in_valid  in  1  input vector valid.
- in_ready  out  1  vector accepted when in_valid && in_ready.
- in_n1, in_n2, in_n3, in_n6, in_n7  in  LANES each  per-lane c17 inputs.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_n22, out_n23  out  LANES each  per-lane results.

## Operation
- Per-lane function, with key k and that lane's feedback register fb:
  - m1 = k1 ? N2 : N1
  - m0 = k0 ? fb : m1
  - N10 = ~(m0 & N3)
  - N11 = ~(N3 & N6)
  - N16 = ~(N2 & N11)
  - N19 = ~(N11 & N7)
  - m3 = k3 ? fb : N10
  - m2 = m3 (k2 is a dummy bit; both mux legs are identical)
  - N22 = ~(m2 & N16)
  - N23 = ~(N16 & N19)
- Correct key: k0 = k1 = k3 = 0, k2 is don't-care. With the correct key the block equals the original c17.
- fb[i] loads the computed N22[i] on every accepted vector. fb is cleared to 0 on reset and at COMMIT.
- FSM states:
  - LOCKED: reset state. in_ready = 0. key_start → SHIFT.
  - SHIFT: each key_valid cycle shifts key_sin into the shadow key and increments the 2-bit count. After the 4th bit → COMMIT. key_start restarts the load (count = 0). in_ready = 0.
  - COMMIT: one cycle. Copies shadow to the active key, clears fb, → ACTIVE.
  - ACTIVE: in_ready = !out_valid || out_ready. key_start → SHIFT; the active key is held until the next COMMIT.
- A key_valid in the same cycle as key_start is ignored; the count resets.
- key_valid outside SHIFT is ignored.
- The output stage drains in any state. A held result is never dropped or altered by a key reload.

## Timing
- Reset values:
  - FSM state: LOCKED
  - active key and shadow key: 0000
  - fb: 0
  - out_valid: 0
  - out_n22, out_n23: 0
  - key_busy: 0
  - in_ready: 0
- Latency: a vector accepted at edge t is presented at out_* with out_valid = 1 after edge t. One vector per cycle at full throughput.
- A held output stays stable until out_ready. out_valid with !out_ready backpressures in_ready to 0.
- Key load timing: key_start at edge t, then 4 key_valid cycles. COMMIT takes one cycle. in_ready can first be high the cycle after COMMIT. Minimum is 6 cycles from key_start to first acceptance.
- fb updates on the same edge as the output register. The next vector sees the previous vector's N22.

## Structure
- Package keyed_c17_pkg holds:
  - KEY_W = 4
  - FSM state enum (LOCKED, SHIFT, COMMIT, ACTIVE)
  - bit-index constants K_M0 = 0, K_M1 = 1, K_M2 = 2, K_M3 = 3
- Sub-module c17_slice: the purely combinational per-lane function (key, fb, N1..N7 → N22, N23). It is instantiated LANES times in a generate loop.
- The top level holds the FSM, key shift register, fb registers and output register.

## Test plan
- Reset, then in_valid = 1 → in_ready stays 0, out_valid stays 0, key_busy stays 0 through 10 cycles.
- Load key 0000. Apply all-ones on every lane → out_n22 = all 1s, out_n23 = all 0s. Then apply all-zeros → out_n22 = 0, out_n23 = 0 (matches c17).
- Load key 1000 (k3 = 1). Apply all-zeros repeatedly → out_n22 alternates 1, 0, 1, 0 per accepted vector (fb feedback). out_n23 stays 0.
- Load key 0100 (k2 only). Apply all-ones → results identical to key 0000, confirming k2 is a dummy bit.
- Hold out_ready = 0 for 5 cycles with in_valid = 1 → one result is held stable, in_ready = 0, no vector is lost. Release → results emerge in input order.
- Mid-load abort: key_start, 2 bits, key_start again, 4 bits → COMMIT uses only the last 4 bits. A key_start in ACTIVE while a result is held → the held result still drains intact.
